// File: rtl/main_fsm_if.sv
// Control bundle between the multicycle controller and its datapath.
// The datapath side drives op/zero/memready; the controller drives the select fields and the strobes.
interface main_fsm_if;
  logic [6:0] op;
  logic       zero;
  logic       memready;
  logic [1:0] ALUOp;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       illegal;
  logic       retire;
  logic [3:0] dbg_state;

  // A strobe fires in every cycle in which it is high.
  // memready=1 means the memory access completes in that same cycle.
  // A stalled access repeats its state until memready is seen.
  modport master (
    output op, zero, memready,
    input  ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
    input  IRWrite, PCWrite, RegWrite, MemWrite, illegal, retire, dbg_state
  );

  modport slave (
    input  op, zero, memready,
    output ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
    output IRWrite, PCWrite, RegWrite, MemWrite, illegal, retire, dbg_state
  );
endinterface

// File: rtl/main_fsm.sv
// Multicycle RISC-V style main controller: Moore FSM with select fields and write strobes.
// Unsupported opcodes park the controller in TRAP until reset.
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  main_fsm_if.slave  bus
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (bus.memready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.memready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (bus.memready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  logic [1:0] alu_op, src_a, src_b, res_src;
  logic       adr_src, ir_write, pc_update, branch, reg_write, mem_write, retire_p;

  always_comb begin
    alu_op    = 2'b00;
    src_a     = 2'b00;
    src_b     = 2'b00;
    res_src   = 2'b00;
    adr_src   = 1'b0;
    ir_write  = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    retire_p  = 1'b0;
    case (state_q)
      S_FETCH: begin
        src_b     = 2'b10;
        res_src   = 2'b10;
        ir_write  = bus.memready;
        pc_update = bus.memready;
      end
      S_DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
      end
      S_MEMADR: begin
        src_a = 2'b10;
        src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        res_src   = 2'b01;
        reg_write = 1'b1;
        retire_p  = 1'b1;
      end
      // The store strobe stays up across the whole memory stall.
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire_p  = bus.memready;
      end
      S_EXECR: begin
        src_a  = 2'b10;
        alu_op = 2'b10;
      end
      S_EXECI: begin
        src_a  = 2'b10;
        src_b  = 2'b01;
        alu_op = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire_p  = 1'b1;
      end
      S_JAL: begin
        src_a     = 2'b01;
        src_b     = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        src_a    = 2'b10;
        alu_op   = 2'b01;
        branch   = 1'b1;
        retire_p = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ALUOp     = alu_op;
  assign bus.ALUSrcA   = src_a;
  assign bus.ALUSrcB   = src_b;
  assign bus.ResultSrc = res_src;
  assign bus.AdrSrc    = adr_src;
  // Strobes are masked by reset directly so they drop without waiting for a clock.
  assign bus.IRWrite   = ir_write  & ~reset;
  assign bus.PCWrite   = (pc_update | (branch & bus.zero)) & ~reset;
  assign bus.RegWrite  = reg_write & ~reset;
  assign bus.MemWrite  = mem_write & ~reset;
  assign bus.retire    = retire_p  & ~reset;
  assign bus.illegal   = (state_q == S_TRAP) & ~reset;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_main_fsm.sv
// Randomized scoreboard bench for main_fsm: per-cycle expected control vectors from a step table.
module tb_main_fsm;
  logic clk = 1'b0;
  logic reset;
  main_fsm_if bus ();

  main_fsm dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3,
                 ST_MEMWB = 4, ST_MEMWRITE = 5, ST_EXECR = 6, ST_EXECI = 7,
                 ST_ALUWB = 8, ST_JAL = 9, ST_BEQ = 10, ST_TRAP = 11;

  logic [14:0] exp_q[$];
  int          step_q[$];
  int          checks = 0;
  int          errors = 0;
  int          retired = 0;
  int          instr_cnt = 0;

  logic [14:0] dut_vec;
  assign dut_vec = {bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.AdrSrc,
                    bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite,
                    bus.illegal, bus.retire};

  // Control word each named step must present, straight from the state table.
  function automatic logic [14:0] model_vec(input int step, input logic mr, input logic z);
    logic [1:0] aluop, srca, srcb, res;
    logic adr, irw, pcw, rw, mw, ill, ret;
    aluop = 2'b00; srca = 2'b00; srcb = 2'b00; res = 2'b00;
    adr = 0; irw = 0; pcw = 0; rw = 0; mw = 0; ill = 0; ret = 0;
    case (step)
      ST_FETCH:    begin srcb = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
      ST_DECODE:   begin srca = 2'b01; srcb = 2'b01; end
      ST_MEMADR:   begin srca = 2'b10; srcb = 2'b01; end
      ST_MEMREAD:  adr = 1;
      ST_MEMWB:    begin res = 2'b01; rw = 1; ret = 1; end
      ST_MEMWRITE: begin adr = 1; mw = 1; ret = mr; end
      ST_EXECR:    begin srca = 2'b10; aluop = 2'b10; end
      ST_EXECI:    begin srca = 2'b10; srcb = 2'b01; aluop = 2'b10; end
      ST_ALUWB:    begin rw = 1; ret = 1; end
      ST_JAL:      begin srca = 2'b01; srcb = 2'b10; pcw = 1; end
      ST_BEQ:      begin srca = 2'b10; aluop = 2'b01; pcw = z; ret = 1; end
      ST_TRAP:     ill = 1;
      default: ;
    endcase
    return {aluop, srca, srcb, res, adr, irw, pcw, rw, mw, ill, ret};
  endfunction

  // mode: 0 force low, 1 force high, 2 random
  task automatic drive_step(input int step, input logic [6:0] op, input int mr_mode, input int z_mode);
    @(posedge clk);
    #1;
    bus.op       = op;
    bus.memready = (mr_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(mr_mode);
    bus.zero     = (z_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(z_mode);
    exp_q.push_back(model_vec(step, bus.memready, bus.zero));
    step_q.push_back(step);
  endtask

  // kind: 0 lw, 1 sw, 2 R, 3 I, 4 jal, 5 beq; f/m = FETCH / memory stall cycles
  task automatic run_instr(input int kind, input int f, input int m, input int zm);
    logic [6:0] op;
    case (kind)
      0: op = 7'b0000011;
      1: op = 7'b0100011;
      2: op = 7'b0110011;
      3: op = 7'b0010011;
      4: op = 7'b1101111;
      default: op = 7'b1100011;
    endcase
    for (int i = 0; i < f; i++) drive_step(ST_FETCH, op, 0, zm);
    drive_step(ST_FETCH, op, 1, zm);
    drive_step(ST_DECODE, op, 2, zm);
    case (kind)
      0: begin
        drive_step(ST_MEMADR, op, 2, zm);
        for (int i = 0; i < m; i++) drive_step(ST_MEMREAD, op, 0, zm);
        drive_step(ST_MEMREAD, op, 1, zm);
        drive_step(ST_MEMWB, op, 2, zm);
      end
      1: begin
        drive_step(ST_MEMADR, op, 2, zm);
        for (int i = 0; i < m; i++) drive_step(ST_MEMWRITE, op, 0, zm);
        drive_step(ST_MEMWRITE, op, 1, zm);
      end
      2: begin drive_step(ST_EXECR, op, 2, zm); drive_step(ST_ALUWB, op, 2, zm); end
      3: begin drive_step(ST_EXECI, op, 2, zm); drive_step(ST_ALUWB, op, 2, zm); end
      4: begin drive_step(ST_JAL, op, 2, zm);   drive_step(ST_ALUWB, op, 2, zm); end
      default: drive_step(ST_BEQ, op, 2, zm);
    endcase
    instr_cnt++;
  endtask

  // Under reset: FETCH select fields, every strobe and the trap flag low, even with memready high.
  task automatic check_reset_out(input string name);
    checks++;
    if (dut_vec !== model_vec(ST_FETCH, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, dut_vec, model_vec(ST_FETCH, 1'b0, 1'b0));
    end
  endtask

  task automatic apply_reset_release();
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.memready = 1'b0;
    reset = 1'b0;
  endtask

  // Monitor: pops one expected control word per driven cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [14:0] e;
        int s;
        e = exp_q.pop_front();
        s = step_q.pop_front();
        checks++;
        if (dut_vec !== e) begin
          errors++;
          $display("FAIL cycle step=%0d dbg_state=%0d got=%h exp=%h", s, bus.dbg_state, dut_vec, e);
        end
      end
      if (bus.retire === 1'b1) retired++;
    end
  end

  initial begin
    bus.op = 7'd0; bus.zero = 1'b0; bus.memready = 1'b1;
    reset = 1'b1;
    #1;
    check_reset_out("reset_at_start");
    apply_reset_release();

    // Directed cases: add, stalled lw, beq taken/not taken, sw with fetch stall, jal, addi, stalled sw.
    run_instr(2, 0, 0, 2);
    run_instr(0, 0, 2, 2);
    run_instr(5, 0, 0, 1);
    run_instr(5, 0, 0, 0);
    run_instr(1, 3, 0, 2);
    run_instr(4, 0, 0, 2);
    run_instr(3, 0, 0, 2);
    run_instr(1, 0, 2, 2);

    for (int n = 0; n < 150; n++) begin
      int kind, f, m;
      kind = $urandom_range(0, 5);
      f = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      m = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      run_instr(kind, f, m, 2);
    end
    @(negedge clk);
    #1;
    checks++;
    if (retired != instr_cnt) begin
      errors++;
      $display("FAIL retire_count got=%0d exp=%0d", retired, instr_cnt);
    end

    // Reset while in EXECR: outputs clear at once and the write-back never happens.
    drive_step(ST_FETCH, 7'b0110011, 1, 2);
    drive_step(ST_DECODE, 7'b0110011, 2, 2);
    drive_step(ST_EXECR, 7'b0110011, 2, 2);
    @(negedge clk);
    #1;
    bus.memready = 1'b1;
    reset = 1'b1;
    #1;
    check_reset_out("reset_in_execr");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_out("reset_hold");
    end
    apply_reset_release();
    run_instr(2, 0, 0, 2);

    // Illegal opcode: trap after DECODE and stay there with no strobes.
    drive_step(ST_FETCH, 7'b1111111, 1, 2);
    drive_step(ST_DECODE, 7'b1111111, 2, 2);
    for (int i = 0; i < 10; i++) drive_step(ST_TRAP, 7'b1111111, 2, 2);
    @(negedge clk);
    #1;
    bus.memready = 1'b1;
    reset = 1'b1;
    #1;
    check_reset_out("reset_from_trap");
    apply_reset_release();
    run_instr(0, 1, 1, 2);
    run_instr(5, 0, 0, 1);

    @(negedge clk);
    #1;
    checks++;
    if (retired != instr_cnt || exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_retire got=%0d exp=%0d pending=%0d", retired, instr_cnt, exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
